// File: rtl/led_pulse_counter_mc.sv
// led_pulse_counter_mc: multi-channel synchronised, debounced pulse counter with LED readout
module led_pulse_counter_mc #(
  parameter int NCH         = 4,
  parameter int CW          = 8,
  parameter int LED_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYC      = 1,
  parameter int SELW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              i_SCLK,
  input  logic              i_RESET_SYSB,
  input  logic [NCH-1:0]    i_PULSE,
  input  logic              i_MODE_EDGE,
  input  logic              i_SAT,
  input  logic              i_CLR,
  input  logic [SELW-1:0]   i_SEL,
  output logic [LED_W-1:0]  o_LED,
  output logic [NCH*CW-1:0] o_COUNT,
  output logic [NCH-1:0]    o_OVF
);
  localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0][DBW-1:0]         dbc_q, dbc_d;
  logic [NCH-1:0]                  acc_q, acc_d, prev_q, prev_d, ovf_q, ovf_d, ev;
  logic [NCH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [LED_W-1:0]                led_q, led_d;
  // Synchronise each input, then accept a new level only after it persists DB_CYC cycles
  always_comb begin
    sync_d = sync_q;
    dbc_d  = '0;
    acc_d  = acc_q;
    for (int n = 0; n < NCH; n++) begin
      sync_d[n] = {sync_q[n][SYNC_STAGES-2:0], i_PULSE[n]};
      if (sync_q[n][SYNC_STAGES-1] != acc_q[n]) begin
        if (dbc_q[n] == DBW'(DB_CYC - 1)) acc_d[n] = sync_q[n][SYNC_STAGES-1];
        else dbc_d[n] = dbc_q[n] + 1'b1;
      end
    end
  end
  assign prev_d = acc_q;
  assign ev     = i_MODE_EDGE ? (acc_q & ~prev_q) : acc_q;
  // Count events with wrap or saturate at all-ones; clear takes priority over an event
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int n = 0; n < NCH; n++) begin
      if (i_CLR) begin
        cnt_d[n] = '0;
        ovf_d[n] = 1'b0;
      end else if (ev[n]) begin
        if (&cnt_q[n]) begin
          cnt_d[n] = i_SAT ? cnt_q[n] : '0;
          ovf_d[n] = 1'b1;
        end else cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end
  assign led_d = ({1'b0, i_SEL} < (SELW+1)'(NCH)) ? cnt_q[i_SEL][LED_W-1:0] : '0;
  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge i_SCLK or negedge i_RESET_SYSB) begin
    if (!i_RESET_SYSB) begin
      sync_q <= '0;
      dbc_q  <= '0;
      acc_q  <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      led_q  <= '0;
    end else begin
      sync_q <= sync_d;
      dbc_q  <= dbc_d;
      acc_q  <= acc_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      led_q  <= led_d;
    end
  end
  assign o_COUNT = cnt_q;
  assign o_OVF   = ovf_q;
  assign o_LED   = led_q;
endmodule

// File: tb/tb_led_pulse_counter_mc.sv
// tb_led_pulse_counter_mc: directed self-checking bench for led_pulse_counter_mc
module tb_led_pulse_counter_mc;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mode = 1'b1, sat = 1'b0, clr = 1'b0;
  logic [3:0] p0 = '0;
  logic [2:0] p1 = '0;
  logic [1:0] sel0 = '0, sel1 = '0;
  logic [3:0] led0, led1;
  logic [31:0] cnt0;
  logic [11:0] cnt1;
  logic [3:0] ovf0;
  logic [2:0] ovf1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  led_pulse_counter_mc u0 (
    .i_SCLK(clk), .i_RESET_SYSB(rst_n), .i_PULSE(p0), .i_MODE_EDGE(mode), .i_SAT(sat),
    .i_CLR(clr), .i_SEL(sel0), .o_LED(led0), .o_COUNT(cnt0), .o_OVF(ovf0)
  );
  led_pulse_counter_mc #(.NCH(3), .CW(4), .LED_W(4), .DB_CYC(4)) u1 (
    .i_SCLK(clk), .i_RESET_SYSB(rst_n), .i_PULSE(p1), .i_MODE_EDGE(mode), .i_SAT(sat),
    .i_CLR(clr), .i_SEL(sel1), .o_LED(led1), .o_COUNT(cnt1), .o_OVF(ovf1)
  );
  task automatic tick(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      p0 = 4'($urandom);
      p1 = 3'($urandom);
      tick();
    end
    chk("rst_led0", led0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_cnt1", cnt1, 0);
    p0 = '0;
    p1 = '0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("idle_cnt0", cnt0, 0);
    p0[0] = 1'b1;
    tick(3);
    chk("edge_before_lat", cnt0[7:0], 0);
    tick();
    chk("edge_first_inc", cnt0[7:0], 1);
    tick();
    chk("edge_led_lat", led0, 1);
    tick(5);
    p0[0] = 1'b0;
    tick(10);
    for (int r = 0; r < 2; r++) begin
      p0[0] = 1'b1;
      tick(10);
      p0[0] = 1'b0;
      tick(10);
    end
    chk("edge_cnt0", cnt0[7:0], 3);
    chk("edge_led0", led0, 4'h3);
    chk("edge_others", cnt0[31:8], 0);
    mode = 1'b0;
    tick(2);
    p0[2] = 1'b1;
    tick(20);
    p0[2] = 1'b0;
    tick(8);
    chk("level_cnt2", cnt0[23:16], 20);
    chk("level_cnt0", cnt0[7:0], 3);
    mode = 1'b1;
    sel0 = 2'd2;
    tick();
    chk("level_led_sel2", led0, 4'h4);
    for (int g = 1; g <= 3; g++) begin
      p1[1] = 1'b1;
      tick(g);
      p1[1] = 1'b0;
      tick(10);
    end
    chk("db_glitch", cnt1[7:4], 0);
    p1[1] = 1'b1;
    tick(4);
    p1[1] = 1'b0;
    tick(12);
    chk("db_accept", cnt1[7:4], 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_all0", cnt0, 0);
    chk("clr_all1", cnt1, 0);
    for (int r = 0; r < 17; r++) begin
      p1[0] = 1'b1;
      tick(6);
      p1[0] = 1'b0;
      tick(6);
    end
    tick(6);
    chk("wrap_cnt", cnt1[3:0], 1);
    chk("wrap_ovf", ovf1, 3'b001);
    clr = 1'b1;
    sat = 1'b1;
    tick();
    clr = 1'b0;
    for (int r = 0; r < 17; r++) begin
      p1[0] = 1'b1;
      tick(6);
      p1[0] = 1'b0;
      tick(6);
    end
    tick(6);
    chk("sat_cnt", cnt1[3:0], 15);
    chk("sat_ovf", ovf1, 3'b001);
    chk("sat_led", led1, 4'hF);
    sel1 = 2'd3;
    tick();
    chk("sel_oob_led", led1, 0);
    sel1 = 2'd0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_cnt1", cnt1, 0);
    chk("clr_ovf1", ovf1, 0);
    sat = 1'b0;
    p0[1] = 1'b1;
    tick(3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_vs_ev", cnt0[15:8], 0);
    tick(6);
    chk("no_recount", cnt0[15:8], 0);
    p0[1] = 1'b0;
    tick(6);
    for (int r = 0; r < 2; r++) begin
      p0 = 4'hF;
      tick(3);
      p0 = 4'h0;
      tick(5);
    end
    tick(4);
    chk("all_ch", cnt0, {4{8'd2}});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt0, 0);
    chk("async_rst_led", led0, 0);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
